// File: rtl/vx_raster_agent_mc.sv
// Raster agent: arbitrates stamp beats from several raster bus channels into
// execute requests and returns per-lane results through a small response FIFO.
module vx_raster_agent_mc #(
  parameter int NUM_LANES    = 4,
  parameter int NUM_CHANNELS = 2,
  parameter int RSP_DEPTH    = 4,
  parameter int WARP_CNT     = 4,
  parameter int PID_W        = 8,
  parameter int UUID_W       = 44,
  localparam int WID_W = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1,
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                exec_valid,
  output logic                                exec_ready,
  input  logic [UUID_W-1:0]                   exec_uuid,
  input  logic [WID_W-1:0]                    exec_wid,
  input  logic [NUM_LANES-1:0]                exec_tmask,
  input  logic [4:0]                          exec_rd,
  input  logic [NUM_CHANNELS-1:0]             bus_valid,
  output logic [NUM_CHANNELS-1:0]             bus_ready,
  input  logic [NUM_CHANNELS-1:0]             bus_done,
  input  logic [NUM_CHANNELS*NUM_LANES*PID_W-1:0] bus_pid,
  input  logic                                done_clear,
  output logic                                commit_valid,
  input  logic                                commit_ready,
  output logic [UUID_W-1:0]                   commit_uuid,
  output logic [WID_W-1:0]                    commit_wid,
  output logic [NUM_LANES-1:0]                commit_tmask,
  output logic [4:0]                          commit_rd,
  output logic [NUM_LANES*32-1:0]             commit_data,
  output logic                                commit_wb,
  output logic [CNT_W-1:0]                    rsp_count,
  output logic                                all_done,
  output logic [31:0]                         stamp_count
);

  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PTR_W = $clog2(RSP_DEPTH);

  typedef struct packed {
    logic [UUID_W-1:0]      uuid;
    logic [WID_W-1:0]       wid;
    logic [NUM_LANES-1:0]   tmask;
    logic [4:0]             rd;
    logic [NUM_LANES*32-1:0] data;
  } rsp_t;

  rsp_t                    mem [RSP_DEPTH];
  rsp_t                    wr_entry;
  rsp_t                    head;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [NUM_CHANNELS-1:0] done_latch, eligible;
  logic [CH_W-1:0]         rr_ptr, grant;
  logic                    grant_ok, full, bus_fire, local_fire, push, pop;

  // Round-robin search starting at rr_ptr over channels that still owe beats.
  always_comb begin
    eligible = bus_valid & ~done_latch;
    grant    = '0;
    grant_ok = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
      if (!grant_ok && eligible[idx]) begin
        grant    = CH_W'(idx);
        grant_ok = 1'b1;
      end
    end
  end

  assign all_done   = &done_latch;
  assign full       = (rsp_count == CNT_W'(RSP_DEPTH));
  assign bus_fire   = reset && exec_valid && grant_ok && !full;
  assign local_fire = reset && exec_valid && all_done && !full;
  assign exec_ready = reset && !full && (grant_ok || all_done);
  assign push       = bus_fire || local_fire;
  assign pop        = commit_valid && commit_ready;

  // Lane word is {pid, live}; a frame-done reply is all zeros.
  always_comb begin
    bus_ready = '0;
    if (bus_fire) bus_ready[grant] = 1'b1;
    wr_entry.uuid  = exec_uuid;
    wr_entry.wid   = exec_wid;
    wr_entry.tmask = exec_tmask;
    wr_entry.rd    = exec_rd;
    wr_entry.data  = '0;
    if (bus_fire) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_entry.data[i*32 +: 32] =
          32'({bus_pid[(int'(grant)*NUM_LANES + i)*PID_W +: PID_W], ~bus_done[grant]});
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rsp_count   <= '0;
      done_latch  <= '0;
      rr_ptr      <= '0;
      stamp_count <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every read in this block sees pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      rsp_count <= rsp_count + CNT_W'(1);
      else if (pop && !push) rsp_count <= rsp_count - CNT_W'(1);
      if (bus_fire) rr_ptr <= (grant == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant + 1'b1;
      if (bus_fire && !bus_done[grant]) stamp_count <= stamp_count + 32'd1;
      if (done_clear)                       done_latch        <= '0;
      else if (bus_fire && bus_done[grant]) done_latch[grant] <= 1'b1;
    end
  end

  // NOTE: the entry array is deliberately not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head         = mem[rd_ptr];
  assign commit_valid = (rsp_count != '0);
  assign commit_uuid  = head.uuid;
  assign commit_wid   = head.wid;
  assign commit_tmask = head.tmask;
  assign commit_rd    = head.rd;
  assign commit_data  = head.data;
  assign commit_wb    = 1'b1;

endmodule
